// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_param_pkg: shared defaults and width helper for the parametrised FIFO
package sync_fifo_param_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 9;
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake, level and error signals of the FIFO
interface sync_fifo_param_if
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic                      wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic                      rd_en;
  logic [DATA_W-1:0]         rd_data;
  logic                      rd_valid;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(ADDR_W)-1:0]  count;
  logic                      clr_err;
  logic                      overflow;
  logic                      underflow;
  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_ram.sv
// sdp_ram_param: simple dual-port RAM, registered read output, array left unreset
module sdp_ram_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // write port: array has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // read port: only the output register is reset, which also drops an in-flight read
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level flags and sticky errors
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = 2**ADDR_W - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  f
);
  localparam int CW    = cnt_w(ADDR_W);
  localparam int DEPTH = 2**ADDR_W;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rd_valid_q, ovf_q, ovf_d, unf_q, unf_d;
  logic              wr_acc, rd_acc;
  assign f.full         = count_q == CW'(DEPTH);
  assign f.empty        = count_q == '0;
  assign f.almost_full  = count_q >= CW'(AFULL_TH);
  assign f.almost_empty = count_q <= CW'(AEMPTY_TH);
  assign f.count        = count_q;
  assign f.rd_valid     = rd_valid_q;
  assign f.overflow     = ovf_q;
  assign f.underflow    = unf_q;
  // accept decisions use only registered flags; errors set over a same-cycle clear
  always_comb begin
    wr_acc   = f.wr_en && !f.full;
    rd_acc   = f.rd_en && !f.empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (wr_acc && !rd_acc) ? count_q + 1'b1 :
               (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
    ovf_d    = (f.wr_en && f.full) || (ovf_q && !f.clr_err);
    unf_d    = (f.rd_en && f.empty) || (unf_q && !f.clr_err);
  end
  // state registers; reset beats any access in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
  sdp_ram_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr_q),
    .wdata (f.wr_data),
    .re    (rd_acc && !rst),
    .raddr (rd_ptr_q),
    .q     (f.rd_data)
  );
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for the 16x8 FIFO configuration
module tb_sync_fifo_param;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  always #5 clk = ~clk;
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(3)) f ();
  sync_fifo_param #(
    .DATA_W    (16),
    .ADDR_W    (3),
    .AFULL_TH  (6),
    .AEMPTY_TH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .f   (f)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, want);
    end
  endtask
  task automatic cyc(input logic w, input logic [15:0] wd, input logic r,
                     input logic c = 1'b0, input logic rs = 1'b0);
    f.wr_en = w; f.wr_data = wd; f.rd_en = r; f.clr_err = c; rst = rs;
    @(posedge clk); #1;
    f.wr_en = 0; f.rd_en = 0; f.clr_err = 0; rst = 0;
  endtask
  task automatic rd(input logic [15:0] e, input logic w = 1'b0, input logic [15:0] wd = 16'h0);
    exp_q.push_back(e);
    cyc(w, wd, 1'b1);
    chk("rd_valid", {31'b0, f.rd_valid}, 32'd1);
  endtask
  task automatic flags(input int c);
    chk("count", {28'b0, f.count}, c);
    chk("empty", {31'b0, f.empty}, (c == 0) ? 1 : 0);
    chk("full", {31'b0, f.full}, (c == 8) ? 1 : 0);
    chk("almost_empty", {31'b0, f.almost_empty}, (c <= 2) ? 1 : 0);
    chk("almost_full", {31'b0, f.almost_full}, (c >= 6) ? 1 : 0);
  endtask
  // monitor: every rd_valid must match the next expected word
  initial begin
    forever begin
      @(negedge clk);
      if (f.rd_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_valid_unexpected got=1 want=0 data=%0h", f.rd_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (f.rd_data !== e) begin
            bad++;
            $display("FAIL rd_data got=%0h want=%0h", f.rd_data, e);
          end
        end
      end
    end
  end
  initial begin
    f.wr_en = 0; f.wr_data = 0; f.rd_en = 0; f.clr_err = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    flags(0);
    chk("rst_rd_valid", {31'b0, f.rd_valid}, 0);
    chk("rst_rd_data", {16'b0, f.rd_data}, 0);
    chk("rst_overflow", {31'b0, f.overflow}, 0);
    chk("rst_underflow", {31'b0, f.underflow}, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 16'(i), 1'b0);
      flags(i);
    end
    for (int i = 1; i <= 8; i++) begin
      rd(16'(i));
      flags(8 - i);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0010 + 16'(i), 1'b0);
    flags(8);
    rd(16'h0010, 1'b1, 16'hAAAA);
    flags(7);
    chk("ovf_set", {31'b0, f.overflow}, 1);
    chk("ovf_no_unf", {31'b0, f.underflow}, 0);
    for (int i = 1; i < 8; i++) rd(16'h0010 + 16'(i));
    flags(0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("ovf_clr", {31'b0, f.overflow}, 0);
    cyc(1'b1, 16'hBEEF, 1'b1);
    flags(1);
    chk("unf_no_readthrough", {31'b0, f.rd_valid}, 0);
    chk("unf_set", {31'b0, f.underflow}, 1);
    rd(16'hBEEF);
    flags(0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("unf_clr", {31'b0, f.underflow}, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0);
    flags(4);
    for (int k = 0; k < 20; k++) begin
      rd(16'h0100 + 16'(k), 1'b1, 16'h0104 + 16'(k));
      chk("wrap_count", {28'b0, f.count}, 4);
    end
    for (int k = 20; k < 24; k++) rd(16'h0100 + 16'(k));
    flags(0);
    cyc(1'b0, 16'h0, 1'b1);
    chk("unf_pre_rst", {31'b0, f.underflow}, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0);
    flags(5);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    flags(0);
    chk("midrst_rd_valid", {31'b0, f.rd_valid}, 0);
    chk("midrst_rd_data", {16'b0, f.rd_data}, 0);
    chk("midrst_overflow", {31'b0, f.overflow}, 0);
    chk("midrst_underflow", {31'b0, f.underflow}, 0);
    cyc(1'b0, 16'h0, 1'b1);
    chk("err_force", {31'b0, f.underflow}, 1);
    cyc(1'b0, 16'h0, 1'b0);
    chk("err_sticky", {31'b0, f.underflow}, 1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    chk("err_set_wins", {31'b0, f.underflow}, 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("err_clr", {31'b0, f.underflow}, 0);
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
